pack_stream: RTL and testbench

- Streaming lane compactor with cross-beat accumulation.
- Each accepted input beat carries N lanes plus a per-lane valid mask. Valid lanes are compacted toward lane 0, appended to a residual buffer, and emitted only as dense N-lane beats.
- A packet-end marker (in_last) forces a partial tail beat.
- Sits between sparse producers (filter/select stages) and wide consumers; valid/ready on both sides.

---
 rtl/pack_stream_pkg.sv | 32 +++
 rtl/pack_cmpct.sv | 39 +++
 rtl/pack_stream.sv | 167 ++++++++++++++++
 tb/tb_pack_stream.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pack_stream_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : pack_stream_pkg
// Brief    : Shared types and helpers for the pack_stream lane compactor.
// Revision : 1.0
// ============================================================================
package pack_stream_pkg;

    localparam int c_DEF_N = 8;
    localparam int c_MAX_N = 64;
    localparam int IDX_W   = $clog2(c_DEF_N);

    typedef logic [IDX_W:0] idx_t;

    typedef enum logic [0:0] {
        ACC  = 1'b0,
        TAIL = 1'b1
    } state_t;

    // Callers zero-extend their N-wide mask to c_MAX_N bits.
    function automatic int unsigned popcount(input logic [c_MAX_N-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < c_MAX_N; i++) begin
            n += {31'b0, v[i]};
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pack_cmpct.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : pack_cmpct
// Brief    : Combinational prefix-sum compactor; moves masked lanes to lane 0.
// Revision : 1.0
// ============================================================================
module pack_cmpct
    import pack_stream_pkg::*;
#(
    parameter int N = 8,
    parameter int W = 32
) (
    input  logic [N-1:0][W-1:0] in_w,
    input  logic [N-1:0]        in_msk,
    output logic [N-1:0][W-1:0] o_w,
    output logic [$clog2(N):0]  o_k
);

    localparam int IW = $clog2(N);

    logic [IW:0] w_acc;

    // A set lane lands at the count of set lanes below it; that count never exceeds its own index.
    always_comb begin
        w_acc = '0;
        o_w   = '0;
        for (int i = 0; i < N; i++) begin
            if (in_msk[i]) begin
                o_w[w_acc[IW-1:0]] = in_w[i];
            end
            w_acc = w_acc + {{IW{1'b0}}, in_msk[i]};
        end
    end

    assign o_k = (IW+1)'(popcount(c_MAX_N'(in_msk)));

endmodule
`default_nettype wire

// File: rtl/pack_stream.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : pack_stream
// Brief    : Streaming lane compactor accumulating sparse beats into dense beats.
// Revision : 1.0
// ============================================================================
module pack_stream
    import pack_stream_pkg::*;
#(
    parameter int N = 8,
    parameter int W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_vld,
    output logic                in_rdy,
    input  logic [N-1:0][W-1:0] in_w,
    input  logic [N-1:0]        in_msk,
    input  logic                in_last,
    output logic                out_vld_r,
    input  logic                out_rdy,
    output logic [N-1:0][W-1:0] out_r,
    output logic [N-1:0]        out_msk_r,
    output logic                out_last_r
);

    localparam int          IW   = $clog2(N);
    localparam logic [IW:0] c_NI = (IW+1)'(N);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [IW-1:0]           r_cnt;
    logic [IW-1:0]           w_cnt_nxt;
    logic [N-1:0][W-1:0]     r_res;
    logic [N-1:0][W-1:0]     w_res_nxt;
    logic [N-1:0][W-1:0]     w_cmp;
    logic [IW:0]             w_k;
    logic [IW:0]             w_total;
    logic                    w_full;
    logic                    w_gt;
    logic [2*N-1:0][W-1:0]   w_cat;
    logic                    w_load_ok;
    logic                    w_acc;
    logic                    w_ld;
    logic                    w_ld_last;
    logic [N-1:0][W-1:0]     w_ld_w;
    logic [N-1:0]            w_ld_msk;
    logic [N-1:0]            w_msk_total;
    logic [N-1:0]            w_msk_cnt;

    pack_cmpct #(
        .N (N),
        .W (W)
    ) u_cmpct (
        .in_w   (in_w),
        .in_msk (in_msk),
        .o_w    (w_cmp),
        .o_k    (w_k)
    );

    assign w_total   = {1'b0, r_cnt} + w_k;
    assign w_full    = w_total[IW];
    assign w_gt      = (w_total > c_NI);
    assign w_load_ok = !out_vld_r || out_rdy;
    assign in_rdy    = (r_state == ACC) && w_load_ok;
    assign w_acc     = in_vld && in_rdy;

    // Residual occupies entries [0, r_cnt); compacted lanes follow immediately after.
    always_comb begin
        w_cat = '0;
        for (int j = 0; j < N; j++) begin
            w_cat[j] = r_res[j];
        end
        for (int i = 0; i < N; i++) begin
            w_cat[(IW+1)'(i) + {1'b0, r_cnt}] = w_cmp[i];
        end
    end

    always_comb begin
        w_msk_total = '0;
        w_msk_cnt   = '0;
        for (int b = 0; b < N; b++) begin
            w_msk_total[b] = ((IW+1)'(b) < w_total);
            w_msk_cnt[b]   = ((IW+1)'(b) < {1'b0, r_cnt});
        end
    end

    // N is a power of two, so the low IW bits of total are both total and total-N.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_res_nxt   = r_res;
        w_ld        = 1'b0;
        w_ld_w      = w_cat[N-1:0];
        w_ld_msk    = '1;
        w_ld_last   = 1'b0;
        case (r_state)
            ACC: begin
                if (w_acc) begin
                    if (!in_last) begin
                        w_cnt_nxt = w_total[IW-1:0];
                        if (!w_full) begin
                            w_res_nxt = w_cat[N-1:0];
                        end else begin
                            w_ld      = 1'b1;
                            w_res_nxt = w_cat[2*N-1:N];
                        end
                    end else if (!w_gt) begin
                        w_ld      = 1'b1;
                        w_ld_msk  = w_msk_total;
                        w_ld_last = 1'b1;
                        w_cnt_nxt = '0;
                    end else begin
                        w_ld        = 1'b1;
                        w_res_nxt   = w_cat[2*N-1:N];
                        w_cnt_nxt   = w_total[IW-1:0];
                        w_state_nxt = TAIL;
                    end
                end
            end
            TAIL: begin
                if (w_load_ok) begin
                    w_ld        = 1'b1;
                    w_ld_w      = r_res;
                    w_ld_msk    = w_msk_cnt;
                    w_ld_last   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ACC;
                end
            end
            default: begin
                w_state_nxt = ACC;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ACC;
            r_cnt      <= '0;
            out_vld_r  <= 1'b0;
            out_msk_r  <= '0;
            out_last_r <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_ld) begin
                out_vld_r  <= 1'b1;
                out_msk_r  <= w_ld_msk;
                out_last_r <= w_ld_last;
            end else if (w_load_ok) begin
                out_vld_r <= 1'b0;
            end
        end
    end

    // Data storage carries no reset; validity is tracked by r_cnt and out_vld_r.
    always_ff @(posedge clk) begin
        r_res <= w_res_nxt;
        if (w_ld) begin
            out_r <= w_ld_w;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pack_stream.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_pack_stream
// Brief    : Scoreboard bench for pack_stream with N=4, W=8.
// Revision : 1.0
// ============================================================================
module tb_pack_stream;

    localparam int N = 4;
    localparam int W = 8;

    typedef struct packed {
        logic [N*W-1:0] d;
        logic [N-1:0]   m;
        logic           l;
    } beat_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_vld = 1'b0;
    logic           in_rdy;
    logic [N*W-1:0] in_w = '0;
    logic [N-1:0]   in_msk = '0;
    logic           in_last = 1'b0;
    logic           out_vld_r;
    logic           out_rdy = 1'b1;
    logic [N*W-1:0] out_r;
    logic [N-1:0]   out_msk_r;
    logic           out_last_r;

    beat_t          exp_q[$];
    logic [W-1:0]   lane_q[$];
    int             n_chk  = 0;
    int             n_pass = 0;
    int             rdy_mode = 0;

    pack_stream #(
        .N (N),
        .W (W)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .in_vld     (in_vld),
        .in_rdy     (in_rdy),
        .in_w       (in_w),
        .in_msk     (in_msk),
        .in_last    (in_last),
        .out_vld_r  (out_vld_r),
        .out_rdy    (out_rdy),
        .out_r      (out_r),
        .out_msk_r  (out_msk_r),
        .out_last_r (out_last_r)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic logic [N*W-1:0] lmask(input logic [N-1:0] m);
        logic [N*W-1:0] r;
        for (int b = 0; b < N; b++) r[b*W +: W] = {W{m[b]}};
        return r;
    endfunction

    // Reference: flat lane FIFO, cut into dense beats, partial tail on packet end.
    task automatic model_accept(input logic [N*W-1:0] d, input logic [N-1:0] m, input logic l);
        beat_t b;
        int    n;
        for (int i = 0; i < N; i++) if (m[i]) lane_q.push_back(d[i*W +: W]);
        if (lane_q.size() > N || (lane_q.size() == N && !l)) begin
            b = '0;
            for (int i = 0; i < N; i++) b.d[i*W +: W] = lane_q.pop_front();
            b.m = '1;
            exp_q.push_back(b);
        end
        if (l) begin
            b = '0;
            n = 0;
            while (lane_q.size() > 0) begin
                b.d[n*W +: W] = lane_q.pop_front();
                b.m[n] = 1'b1;
                n++;
            end
            b.l = 1'b1;
            exp_q.push_back(b);
        end
    endtask

    beat_t          mon_e;
    logic           p_hold = 1'b0;
    logic [N*W-1:0] p_d;
    logic [N-1:0]   p_m;
    logic           p_l;

    always @(negedge clk) begin
        if (rst) begin
            p_hold = 1'b0;
        end else begin
            if (p_hold) begin
                check_eq("hold_data", out_r, p_d);
                check_eq("hold_msk", out_msk_r, p_m);
                check_eq("hold_last", out_last_r, p_l);
            end
            if (out_vld_r === 1'b1 && !out_rdy) check_eq("bp_in_rdy", in_rdy, 0);
            if (out_vld_r === 1'b1 && out_rdy) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_beat", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_eq("out_msk", out_msk_r, mon_e.m);
                    check_eq("out_last", out_last_r, mon_e.l);
                    check_eq("out_data", out_r & lmask(mon_e.m), mon_e.d & lmask(mon_e.m));
                end
            end
            if (in_vld && in_rdy === 1'b1) model_accept(in_w, in_msk, in_last);
            p_hold = (out_vld_r === 1'b1) && !out_rdy;
            p_d = out_r;
            p_m = out_msk_r;
            p_l = out_last_r;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_rdy = 1'b1;
                1:       out_rdy = ($urandom_range(0, 3) != 0);
                default: out_rdy = 1'b0;
            endcase
        end
    end

    task automatic send(input logic [N*W-1:0] d, input logic [N-1:0] m, input logic l);
        bit acc;
        int t;
        in_vld  = 1'b1;
        in_w    = d;
        in_msk  = m;
        in_last = l;
        acc = 0;
        t   = 0;
        while (!acc && t < 200) begin
            @(negedge clk);
            acc = (in_rdy === 1'b1);
            @(posedge clk);
            #1;
            t++;
        end
        in_vld = 1'b0;
        if (!acc) check_eq("send_timeout", 0, 1);
    endtask

    task automatic drain(input int bound);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < bound) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk);
        #1;
        check_eq("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_vld", out_vld_r, 0);
        check_eq("rst_msk", out_msk_r, 0);
        check_eq("rst_last", out_last_r, 0);
        check_eq("rst_in_rdy", in_rdy, 1);
        @(posedge clk);
        #1;

        // Full-beat passthrough
        send(32'h03020100, 4'b1111, 1'b0);
        @(negedge clk);
        check_eq("pt_vld", out_vld_r, 1);
        check_eq("pt_data", out_r, 32'h03020100);
        check_eq("pt_msk", out_msk_r, 4'b1111);
        drain(20);

        // Cross-beat accumulation, then flush leftover with an empty last beat
        send({8'h00, 8'hA2, 8'h00, 8'hA0}, 4'b0101, 1'b0);
        @(negedge clk);
        check_eq("acc_no_out", out_vld_r, 0);
        @(posedge clk);
        #1;
        send({8'hB3, 8'hB2, 8'hB1, 8'h00}, 4'b1110, 1'b0);
        @(negedge clk);
        check_eq("acc_data", out_r, 32'hB2B1A2A0);
        @(posedge clk);
        #1;
        send(32'h0, 4'b0000, 1'b1);
        drain(20);

        // Tail split over two beats
        send({8'h00, 8'hC2, 8'hC1, 8'hC0}, 4'b0111, 1'b0);
        send({8'hD3, 8'h00, 8'hD1, 8'hD0}, 4'b1011, 1'b1);
        @(negedge clk);
        check_eq("tail_b1_data", out_r, 32'hD0C2C1C0);
        check_eq("tail_b1_last", out_last_r, 0);
        check_eq("tail_in_rdy", in_rdy, 0);
        @(negedge clk);
        check_eq("tail_b2_data", out_r & 32'h0000FFFF, 32'h0000D3D1);
        check_eq("tail_b2_msk", out_msk_r, 4'b0011);
        check_eq("tail_b2_last", out_last_r, 1);
        check_eq("tail_in_rdy_after", in_rdy, 1);
        drain(20);

        // Empty last beat, then exactly-full last beat
        send(32'h0, 4'b0000, 1'b1);
        @(negedge clk);
        check_eq("empty_msk", out_msk_r, 4'b0000);
        check_eq("empty_last", out_last_r, 1);
        drain(20);
        send(32'h44332211, 4'b1111, 1'b1);
        drain(20);

        // Backpressure: a pending beat must wait while the output is stalled
        rdy_mode = 2;
        repeat (2) @(posedge clk);
        #1;
        send(32'h57565554, 4'b1111, 1'b0);
        in_vld  = 1'b1;
        in_w    = 32'h6B6A6968;
        in_msk  = 4'b1001;
        in_last = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check_eq("bp_stall_vld", out_vld_r, 1);
            check_eq("bp_stall_rdy", in_rdy, 0);
        end
        rdy_mode = 0;
        send(32'h6B6A6968, 4'b1001, 1'b1);
        drain(20);

        // Reset mid-packet with a pending output beat and residual lanes
        send({8'h00, 8'h00, 8'hE1, 8'hE0}, 4'b0011, 1'b0);
        rdy_mode = 2;
        repeat (2) @(posedge clk);
        #1;
        send(32'hF3F2F1F0, 4'b1111, 1'b0);
        @(negedge clk);
        check_eq("mid_vld_pending", out_vld_r, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        rdy_mode = 0;
        exp_q.delete();
        lane_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_vld", out_vld_r, 0);
        check_eq("mid_rst_msk", out_msk_r, 0);
        check_eq("mid_rst_last", out_last_r, 0);
        check_eq("mid_rst_in_rdy", in_rdy, 1);
        @(posedge clk);
        #1;
        send({8'h00, 8'h00, 8'h92, 8'h91}, 4'b0011, 1'b1);
        @(negedge clk);
        check_eq("mid_new_data", out_r & 32'h0000FFFF, 32'h00009291);
        check_eq("mid_new_msk", out_msk_r, 4'b0011);
        drain(20);

        // Random stream with random downstream stalls
        rdy_mode = 1;
        for (int i = 0; i < 10000; i++) begin
            send($urandom, 4'($urandom), ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 9) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        send(32'h0, 4'b0000, 1'b1);
        drain(400);
        rdy_mode = 0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
